adsr_envelope: RTL



---
 rtl/adsr_envelope_if.sv | 21 ++
 rtl/adsr_envelope.sv | 134 +++++++++++++
 2 files changed

// File: rtl/adsr_envelope_if.sv
// Control/status bundle between the synthesizer core and the ADSR envelope block.
// master drives gates and envelope settings; slave (the envelope) returns levels.
interface adsr_envelope_if;
    logic [7:0]       gate;
    logic [31:0]      attack_step;
    logic [31:0]      decay_step;
    logic [31:0]      sustain_level;
    logic [31:0]      release_step;
    logic [7:0][31:0] voice_volumes;
    logic [7:0]       active;

    modport master (
        output gate, attack_step, decay_step, sustain_level, release_step,
        input  voice_volumes, active
    );

    modport slave (
        input  gate, attack_step, decay_step, sustain_level, release_step,
        output voice_volumes, active
    );
endinterface

// File: rtl/adsr_envelope.sv
// Eight-voice ADSR envelope generator; one shared update path visits voice k
// on the clock where the prescaler equals k, once per PRESCALE cycles.
module adsr_envelope #(
    parameter int unsigned N_VOICES = 8,
    parameter logic [31:0] PEAK     = 32'h0001_0000,
    parameter int unsigned PRESCALE = 256
) (
    input logic           clk,
    input logic           reset,
    adsr_envelope_if.slave bus
);
    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned VW = $clog2(N_VOICES);
    localparam logic [PW-1:0] PC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PC_NV   = PW'(N_VOICES);

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } state_t;

    logic [PW-1:0]                pcount;
    state_t                       state_q [N_VOICES];
    logic [N_VOICES-1:0][31:0]    level_q;
    logic [N_VOICES-1:0]          gate_prev_q;

    logic                         slot_valid;
    logic [VW-1:0]                slot;
    state_t                       cur_state;
    logic [31:0]                  cur_level;
    logic                         cur_gate;
    logic                         cur_gate_prev;
    logic [31:0]                  sus;
    logic [32:0]                  att_sum;
    logic [32:0]                  dec_floor;
    logic                         att_done;
    logic                         dec_done;
    logic                         rel_done;
    state_t                       nxt_state;
    logic [31:0]                  nxt_level;

    assign slot_valid = (pcount < PC_NV);
    assign slot       = pcount[VW-1:0];

    always_comb begin
        cur_state     = state_q[slot];
        cur_level     = level_q[slot];
        cur_gate      = bus.gate[slot];
        cur_gate_prev = gate_prev_q[slot];
        sus           = (bus.sustain_level > PEAK) ? PEAK : bus.sustain_level;

        // 33-bit compares keep level+step and S+step from wrapping.
        att_sum   = {1'b0, cur_level} + {1'b0, bus.attack_step};
        dec_floor = {1'b0, sus} + {1'b0, bus.decay_step};
        att_done  = (bus.attack_step == '0) || (att_sum >= {1'b0, PEAK});
        dec_done  = (bus.decay_step == '0) || ({1'b0, cur_level} <= dec_floor);
        rel_done  = (bus.release_step == '0) || (cur_level <= bus.release_step);

        nxt_state = cur_state;
        nxt_level = cur_level;

        if (cur_gate && !cur_gate_prev) begin
            if (att_done) begin
                nxt_level = PEAK;
                nxt_state = DECAY;
            end else begin
                nxt_level = att_sum[31:0];
                nxt_state = ATTACK;
            end
        end else if ((!cur_gate && cur_gate_prev && cur_state != IDLE) || cur_state == RELEASE) begin
            if (rel_done) begin
                nxt_level = '0;
                nxt_state = IDLE;
            end else begin
                nxt_level = cur_level - bus.release_step;
                nxt_state = RELEASE;
            end
        end else begin
            case (cur_state)
                ATTACK: begin
                    if (att_done) begin
                        nxt_level = PEAK;
                        nxt_state = DECAY;
                    end else begin
                        nxt_level = att_sum[31:0];
                    end
                end
                DECAY: begin
                    if (dec_done) begin
                        nxt_level = sus;
                        nxt_state = SUSTAIN;
                    end else begin
                        nxt_level = cur_level - bus.decay_step;
                    end
                end
                SUSTAIN: nxt_level = sus;
                default: begin
                    nxt_level = '0;
                    nxt_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcount      <= '0;
            level_q     <= '0;
            gate_prev_q <= '0;
            for (int unsigned i = 0; i < N_VOICES; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            pcount <= (pcount == PC_LAST) ? '0 : pcount + 1'b1;
            if (slot_valid) begin
                state_q[slot]     <= nxt_state;
                level_q[slot]     <= nxt_level;
                gate_prev_q[slot] <= cur_gate;
            end
        end
    end

    assign bus.voice_volumes = level_q;

    always_comb begin
        bus.active = '0;
        for (int unsigned i = 0; i < N_VOICES; i++) begin
            bus.active[i] = (state_q[i] != IDLE);
        end
    end
endmodule
